// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the computer's instruction decoder.
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HI_RSVD_BIT = 7;
  localparam int OPCODE_W    = 7;
  localparam int LIT_W       = 8;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: LEN, N x {HI, LO}, CHK -> instruction memory writes,
// holding the computer in reset until a checksum-verified image has been written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    word_count
);

  localparam int CW   = ADDR_W + 1;
  localparam int HI_W = INSTR_W - LIT_W;
  localparam logic [CW-1:0] LEN_MAX = CW'(1) << ADDR_W;

  state_t          state;
  logic [CW-1:0]   len;
  logic [7:0]      acc;
  logic [HI_W-1:0] hi_bits;
  logic            accept;

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      len        <= '0;
      acc        <= '0;
      hi_bits    <= '0;
      rx_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_reset  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            im_addr    <= '0;
            acc        <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            rx_ready   <= 1'b1;
          end
        end
        S_LEN: begin
          if (accept) begin
            // LEN of zero encodes a full-depth image
            len   <= (rx_data == 8'd0) ? LEN_MAX : CW'(rx_data);
            acc   <= rx_data;
            state <= S_HI;
          end
        end
        S_HI: begin
          if (accept) begin
            acc <= acc ^ rx_data;
            if (rx_data[HI_RSVD_BIT]) begin
              state    <= S_ERR;
              error    <= 1'b1;
              busy     <= 1'b0;
              rx_ready <= 1'b0;
            end else begin
              hi_bits <= rx_data[HI_W-1:0];
              state   <= S_LO;
            end
          end
        end
        S_LO: begin
          if (accept) begin
            acc        <= acc ^ rx_data;
            im_we      <= 1'b1;
            im_addr    <= word_count[ADDR_W-1:0];
            im_wdata   <= {hi_bits, rx_data};
            word_count <= word_count + 1'b1;
            state      <= (word_count + 1'b1 == len) ? S_CHK : S_HI;
          end
        end
        S_CHK: begin
          if (accept) begin
            busy     <= 1'b0;
            rx_ready <= 1'b0;
            if (rx_data == acc) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard checked every cycle.
module tb_program_loader;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 15;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         rx_data = '0;
  logic               rx_valid = 1'b0;
  logic               rx_ready;
  logic               im_we;
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_wdata;
  logic               cpu_reset;
  logic               busy;
  logic               done;
  logic               error;
  logic [ADDR_W:0]    word_count;

  program_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0]  a;
    logic [INSTR_W-1:0] d;
  } wr_t;

  wr_t sb[$];
  bit  we_due = 1'b0;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge; any write must be due.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    chk("im_we", {31'd0, im_we}, {31'd0, we_due});
    if (im_we && sb.size() > 0) begin
      e = sb.pop_front();
      chk("im_addr", 32'(im_addr), 32'(e.a));
      chk("im_wdata", 32'(im_wdata), 32'(e.d));
    end
    we_due = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    chk("rx_ready", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      chk("rx_ready_gap", {31'd0, rx_ready}, 32'd1);
      tick();
    end
  endtask

  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo,
                           input logic [ADDR_W-1:0] a, input int gap);
    wr_t e;
    send(hi, gap);
    e.a = a;
    e.d = {hi[6:0], lo};
    sb.push_back(e);
    we_due = 1'b1;
    send(lo, gap);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("start_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("start_done", {31'd0, done}, 32'd0);
    chk("start_error", {31'd0, error}, 32'd0);
    chk("start_word_count", 32'(word_count), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_im_we"}, {31'd0, im_we}, 32'd0);
    chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_im_wdata"}, 32'(im_wdata), 32'd0);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  // Good 2-word image; chk_byte A9 is the correct XOR of 02^02^64^05^C8.
  task automatic image2(input logic [7:0] chk_byte, input int gap, input bit start_on_chk);
    send(8'h02, gap);
    send_word(8'h02, 8'h64, 8'd0, gap);
    send_word(8'h05, 8'hC8, 8'd1, gap);
    start = start_on_chk;
    send(chk_byte, 0);
    start = 1'b0;
  endtask

  task automatic check_good(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd2);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] hi;
    logic [7:0] lo;

    #1;
    check_idle_outputs("reset");
    #7;
    reset = 1'b1;
    tick();
    tick();
    check_idle_outputs("idle");

    // Good image, with a start coincident with CHK that must be ignored
    do_start();
    image2(8'hA9, 0, 1'b1);
    check_good("good");
    tick();
    chk("good_start_ignored_busy", {31'd0, busy}, 32'd0);
    chk("good_start_ignored_done", {31'd0, done}, 32'd1);

    // Bad checksum
    do_start();
    image2(8'hAA, 0, 1'b0);
    chk("badchk_error", {31'd0, error}, 32'd1);
    chk("badchk_done", {31'd0, done}, 32'd0);
    chk("badchk_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("badchk_busy", {31'd0, busy}, 32'd0);
    chk("badchk_word_count", 32'(word_count), 32'd2);
    chk("badchk_sb_empty", 32'(sb.size()), 32'd0);

    // Reserved HI bit
    do_start();
    send(8'h01, 0);
    send(8'h85, 0);
    chk("rsvd_error", {31'd0, error}, 32'd1);
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rsvd_word_count", 32'(word_count), 32'd0);
    x = 8'h10;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = x;
      chk("rsvd_rx_ready", {31'd0, rx_ready}, 32'd0);
      tick();
      x = x + 8'h10;
    end
    rx_valid = 1'b0;
    chk("rsvd_error_held", {31'd0, error}, 32'd1);

    // Gaps of 3 idle cycles between bytes
    do_start();
    image2(8'hA9, 3, 1'b0);
    check_good("gaps");

    // Full depth: LEN=00, 256 words
    do_start();
    send(8'h00, 0);
    x = 8'h00;
    for (int a = 0; a < 256; a++) begin
      hi = {1'b0, 7'(a)};
      lo = ~8'(a);
      send_word(hi, lo, 8'(a), 0);
      x = x ^ hi ^ lo;
    end
    send(x, 0);
    chk("full_done", {31'd0, done}, 32'd1);
    chk("full_error", {31'd0, error}, 32'd0);
    chk("full_word_count", 32'(word_count), 32'd256);
    chk("full_last_addr", 32'(im_addr), 32'hFF);
    chk("full_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset right after the third byte (a LO) is accepted
    do_start();
    send(8'h02, 0);
    send(8'h02, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h64;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    tick();
    tick();
    check_idle_outputs("midreset_held");
    #2;
    reset = 1'b1;
    tick();
    do_start();
    image2(8'hA9, 0, 1'b0);
    check_good("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
